mac_fp32_deconverter: RTL

- Converts IEEE-754 fp32 values back to scaled signed integers for the MAC datapath.
- Inverse of the integer-to-fp32 output converter: result = round(fp32 × 2^i_exp), saturated to OUT_W bits.
- Sits between the fp32 post-processing stage and the integer requantize/IFM write-back path.
- 2-stage valid/ready pipeline with full backpressure.

---
 rtl/mac_fp32_deconverter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mac_fp32_deconverter.sv
// fp32 -> scaled signed integer deconverter: round(x * 2^i_exp), saturated to OUT_W bits.
// Optional saturation event counter enabled by defining MAC_FP32_DECONV_STAT_EN.
module mac_fp32_deconverter #(
  parameter int OUT_W     = 34,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_data,
  input  logic [5:0]           i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_W-1:0]     o_data,
  output logic                 o_sat,
  output logic                 o_nan,
  output logic [SAT_CNT_W-1:0] o_sat_cnt
);

  localparam int STAGES = 2;
  localparam int MAG_W  = OUT_W + 24;

  localparam logic [MAG_W-1:0]  POS_LIM  = (MAG_W'(1) << (OUT_W-1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0]  NEG_LIM  = MAG_W'(1) << (OUT_W-1);
  localparam logic [OUT_W-1:0]  SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [9:0] OUT_W_S  = 10'(OUT_W);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // ---------------- handshake ----------------
  logic [STAGES:1] r_vld_pipe;
  logic            w_en1, w_en2;

  assign w_en2   = ~r_vld_pipe[2] | i_ready;
  assign w_en1   = ~r_vld_pipe[1] | w_en2;
  assign o_ready = w_en1;
  assign o_valid = r_vld_pipe[2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_en1) r_vld_pipe[1] <= i_valid;
      if (w_en2) r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  // ---------------- stage 1: decode ----------------
  logic [7:0]        w_e;
  logic [22:0]       w_m;
  cls_e              w_cls;
  logic signed [9:0] w_shift;

  assign w_e     = i_data[30:23];
  assign w_m     = i_data[22:0];
  assign w_shift = $signed({2'b00, w_e}) - 10'sd150 + $signed({{4{i_exp[5]}}, i_exp});

  always_comb begin
    w_cls = CLS_NORM;
    if (w_e == 8'd0)        w_cls = CLS_ZERO;
    else if (w_e == 8'hFF)  w_cls = (w_m != 23'd0) ? CLS_NAN : CLS_INF;
  end

  logic              r_sign;
  cls_e              r_cls;
  logic [23:0]       r_mag24;
  logic signed [9:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sign  <= 1'b0;
      r_cls   <= CLS_ZERO;
      r_mag24 <= '0;
      r_shift <= '0;
    end else if (w_en1 && i_valid) begin
      r_sign  <= i_data[31];
      r_cls   <= w_cls;
      r_mag24 <= {1'b1, w_m};
      r_shift <= w_shift;
    end
  end

  // ---------------- stage 2: shift / round / saturate ----------------
  logic [9:0]       w_k;
  logic [MAG_W-1:0] w_mag;
  logic             w_ovf;
  logic [OUT_W-1:0] w_nxt_data;
  logic             w_nxt_sat, w_nxt_nan;

  assign w_k = 10'(-r_shift);

  always_comb begin
    w_mag      = '0;
    w_ovf      = 1'b0;
    w_nxt_data = '0;
    w_nxt_sat  = 1'b0;
    w_nxt_nan  = 1'b0;
    unique case (r_cls)
      CLS_NAN: w_nxt_nan = 1'b1;
      CLS_INF: w_ovf     = 1'b1;
      CLS_NORM: begin
        if (!r_shift[9]) begin
          // the implicit leading one guarantees overflow once E reaches OUT_W
          if (r_shift >= OUT_W_S) w_ovf = 1'b1;
          else                    w_mag = MAG_W'(r_mag24) << r_shift[5:0];
        end else if (w_k < 10'd25) begin
          w_mag = (MAG_W'(r_mag24) + (MAG_W'(1) << (w_k[4:0] - 5'd1))) >> w_k[4:0];
        end
        if (r_sign ? (w_mag > NEG_LIM) : (w_mag > POS_LIM)) w_ovf = 1'b1;
      end
      default: ;
    endcase
    if (w_ovf) begin
      w_nxt_data = r_sign ? SAT_NEG : SAT_POS;
      w_nxt_sat  = 1'b1;
    end else if (r_cls == CLS_NORM) begin
      w_nxt_data = r_sign ? -w_mag[OUT_W-1:0] : w_mag[OUT_W-1:0];
    end
  end

  logic [OUT_W-1:0] r_data;
  logic             r_sat, r_nan;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_sat  <= 1'b0;
      r_nan  <= 1'b0;
    end else if (w_en2 && r_vld_pipe[1]) begin
      r_data <= w_nxt_data;
      r_sat  <= w_nxt_sat;
      r_nan  <= w_nxt_nan;
    end
  end

  assign o_data = r_data;
  assign o_sat  = r_sat;
  assign o_nan  = r_nan;

  // ---------------- saturation statistics ----------------
`ifdef MAC_FP32_DECONV_STAT_EN
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_sat_cnt <= '0;
    else if (r_vld_pipe[2] && i_ready && r_sat && (r_sat_cnt != {SAT_CNT_W{1'b1}}))
      r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
  end

  assign o_sat_cnt = r_sat_cnt;
`else
  assign o_sat_cnt = '0;
`endif

endmodule
